alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester round-robin arbiter that shares the single EX-stage `alu` (i1, i2, op -> dout, zero, sign) between the pipeline's EX stage and a secondary client such as the branch/compare unit. It accepts one operation per cycle and registers the selected operands into the ALU inputs. It then captures the ALU's combinational result one cycle later and returns it tagged with the requester id.

## Interface
- `WIDTH`, 32, datapath width of operands and result.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  when high, no new grant is issued; in-flight operation still completes.
- `req0`, `req1`  in  1  request from requester 0 / 1; held high with operands stable until granted.
- `a0`, `b0`, `a1`, `b1`  in  WIDTH  operands of requester 0 / 1.
- `op0`, `op1`  in  2  ALU opcode of requester 0 / 1 (00 add, 01 sub a-b, 10 or, 11 reserved, passed through unchanged).
- `gnt0`, `gnt1`  out  1  combinational grant; request is accepted at the rising edge where `gnt` is high.
- `alu_i1`, `alu_i2`  out  WIDTH  registered operands to the ALU.
- `alu_op`  out  2  registered opcode to the ALU.
- `alu_dout`  in  WIDTH  ALU result (combinational from `alu_i1/alu_i2/alu_op`).
- `alu_zero`, `alu_sign`  in  1  ALU flags.
- `rsp_valid`  out  1  one-cycle pulse; response fields valid.
- `rsp_id`  out  1  requester that owns the response.
- `rsp_dout`  out  WIDTH  captured result.
- `rsp_zero`, `rsp_sign`  out  1  captured flags.

## Operation
- State: `last` (id of last granted requester), issue stage (`alu_i1/i2/op`, `iss_valid`, `iss_id`), response stage (`rsp_*`).
- Grant logic (combinational, all gnt = 0 while `rst` or `stall` high):
  - Only one requester active: that one is granted.
  - Both active: the requester != `last` is granted.
  - None active: no grant, `last` unchanged.
- At an edge with a grant to k:
  - `alu_i1 <= ak`, `alu_i2 <= bk`, `alu_op <= opk`.
  - `iss_valid <= 1`, `iss_id <= k`, `last <= k`.
- At an edge without a grant:
  - `iss_valid <= 0`.
  - `alu_i1/alu_i2/alu_op` hold their value (no needless ALU toggling).
- Response stage, every edge:
  - `rsp_valid <= iss_valid`.
  - If `iss_valid`: `rsp_id <= iss_id`, `rsp_dout <= alu_dout`, `rsp_zero <= alu_zero`, `rsp_sign <= alu_sign`.
  - Otherwise the `rsp_*` data fields hold.
- Arithmetic: none inside the block; operands, opcode and result pass through bit-exact at `WIDTH` bits.
- Reserved opcode 11 is forwarded as-is; the response is whatever the ALU returns.
- Reset values (asynchronous, immediate on `rst` high):
  - `alu_i1 = 0`, `alu_i2 = 0`, `alu_op = 00`.
  - `iss_valid = 0`, `iss_id = 0`, `last = 1` (requester 0 wins the first tie).
  - `rsp_valid = 0`, `rsp_id = 0`, `rsp_dout = 0`, `rsp_zero = 0`, `rsp_sign = 0`.

## Timing
- Throughput: one grant per cycle; back-to-back grants fully pipelined.
- Latency: a grant accepted at edge E0 appears on `alu_*` after E0 and on `rsp_*` (with `rsp_valid = 1`) after E1. Two edges from acceptance to response.
- Fairness: with both requesting continuously and `stall = 0`, grants alternate 0,1,0,1,...; neither requester waits more than one cycle.
- Requester drops `req` in the same cycle as its grant: the grant still stands (accepted at that edge).
- A `req` rising in the same cycle as the other's grant is not granted that cycle.
- `stall` high: `gnt0 = gnt1 = 0` and `iss_valid <= 0`. An operation issued at the edge before the stall still produces `rsp_valid` at the next edge. `last` does not change.
- `stall` falling: arbitration resumes from the current `last`.
- Reset mid-operation: in-flight issue and response are discarded, and no `rsp_valid` pulse is produced for them. The first grant after reset release goes to requester 0 if both request.

## Test plan
- Single request: `req0=1, a0=5, b0=7, op0=00` for one cycle -> `gnt0=1`; two edges later `rsp_valid=1, rsp_id=0, rsp_dout=0000000C, rsp_zero=0, rsp_sign=0`.
- Sub with sign: `req1=1, a1=5, b1=7, op1=01` -> `rsp_id=1, rsp_dout=FFFFFFFE, rsp_sign=1`. Then `a1=7, b1=7, op1=01` -> `rsp_dout=0, rsp_zero=1`.
- Contention: both requesters held high for 4 cycles, with req0 doing `5 or 7` and req1 doing `5+7` -> grants 0,1,0,1. Responses `00000007`/id0 and `0000000C`/id1 alternate on consecutive cycles with `rsp_valid` continuously high.
- Stall: both requesting, `stall=1` for 3 cycles right after one grant -> the already-issued op responds once, then `rsp_valid=0` for the stall window. After release, the other requester wins first.
- Reset mid-flight: grant at edge E0, `rst` pulsed between E0 and E1 -> no `rsp_valid` ever appears for that op, and all outputs read their reset values. After release with both requesting, `gnt0=1` first.
- Idle hold: a grant with `a0=5`, then no requests for 3 cycles -> `alu_i1` stays 5, `rsp_dout` holds 0000000C, `rsp_valid=0`.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters: issue stage drives
// the ALU operands, response stage captures the result tagged with the owner id.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] alu_i1,
    output logic [WIDTH-1:0] alu_i2,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_dout,
    input  logic             alu_zero,
    input  logic             alu_sign,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_dout,
    output logic             rsp_zero,
    output logic             rsp_sign
);

    logic last;
    logic vld_p0;
    logic id_p0;

    // On a tie the requester that did not win last time gets the ALU.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && !stall) begin
            if (req0 && req1) begin
                gnt0 = last;
                gnt1 = ~last;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // ---- stage p0: issue operands to the ALU ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_i1 <= '0;
            alu_i2 <= '0;
            alu_op <= 2'b00;
            vld_p0 <= 1'b0;
            id_p0  <= 1'b0;
            last   <= 1'b1;
        end else begin
            vld_p0 <= gnt0 | gnt1;
            if (gnt0 | gnt1) begin
                alu_i1 <= gnt1 ? a1 : a0;
                alu_i2 <= gnt1 ? b1 : b0;
                alu_op <= gnt1 ? op1 : op0;
                id_p0  <= gnt1;
                last   <= gnt1;
            end
        end
    end

    // ---- stage p1: capture the ALU result ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_dout  <= '0;
            rsp_zero  <= 1'b0;
            rsp_sign  <= 1'b0;
        end else begin
            rsp_valid <= vld_p0;
            if (vld_p0) begin
                rsp_id   <= id_p0;
                rsp_dout <= alu_dout;
                rsp_zero <= alu_zero;
                rsp_sign <= alu_sign;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU closing the loop.
module tb_alu_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall;
    logic             req0, req1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic [1:0]       op0, op1;
    logic             gnt0, gnt1;
    logic [WIDTH-1:0] alu_i1, alu_i2;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] alu_dout;
    logic             alu_zero, alu_sign;
    logic             rsp_valid, rsp_id;
    logic [WIDTH-1:0] rsp_dout;
    logic             rsp_zero, rsp_sign;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .op0(op0), .op1(op1),
        .gnt0(gnt0), .gnt1(gnt1),
        .alu_i1(alu_i1), .alu_i2(alu_i2), .alu_op(alu_op),
        .alu_dout(alu_dout), .alu_zero(alu_zero), .alu_sign(alu_sign),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_dout(rsp_dout),
        .rsp_zero(rsp_zero), .rsp_sign(rsp_sign)
    );

    // Reference ALU: add, sub, or; reserved code returns and.
    always_comb begin
        case (alu_op)
            2'b00:   alu_dout = alu_i1 + alu_i2;
            2'b01:   alu_dout = alu_i1 - alu_i2;
            2'b10:   alu_dout = alu_i1 | alu_i2;
            default: alu_dout = alu_i1 & alu_i2;
        endcase
        alu_zero = (alu_dout == '0);
        alu_sign = alu_dout[WIDTH-1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic id,
                           input logic [31:0] d, input logic z, input logic s);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'(v));
        chk({tag, "_id"},    32'(rsp_id),    32'(id));
        chk({tag, "_dout"},  rsp_dout,       d);
        chk({tag, "_zero"},  32'(rsp_zero),  32'(z));
        chk({tag, "_sign"},  32'(rsp_sign),  32'(s));
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0;
        req0 = 1'b1; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = 2'b00; op1 = 2'b00;
        step(); step();
        // reset state, grants suppressed while rst is high
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_alu_i1", alu_i1, 32'd0);
        chk("rst_alu_i2", alu_i2, 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk_rsp("rst_rsp", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        req0 = 1'b0;
        rst = 1'b0;
        #1;

        // single add from requester 0
        req0 = 1'b1; a0 = 32'd5; b0 = 32'd7; op0 = 2'b00;
        #1;
        chk("single_gnt0", 32'(gnt0), 32'd1);
        chk("single_gnt1", 32'(gnt1), 32'd0);
        step();
        req0 = 1'b0;
        chk("single_alu_i1", alu_i1, 32'd5);
        chk("single_alu_i2", alu_i2, 32'd7);
        chk("single_alu_op", 32'(alu_op), 32'd0);
        chk("single_lat", 32'(rsp_valid), 32'd0);
        step();
        chk_rsp("single_rsp", 1'b1, 1'b0, 32'h0000000C, 1'b0, 1'b0);
        step();
        chk("single_pulse", 32'(rsp_valid), 32'd0);

        // subtract with negative result, then with zero result
        req1 = 1'b1; a1 = 32'd5; b1 = 32'd7; op1 = 2'b01;
        #1;
        chk("sub_gnt1", 32'(gnt1), 32'd1);
        step();
        req1 = 1'b0;
        step();
        chk_rsp("sub_neg", 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1);
        req1 = 1'b1; a1 = 32'd7; b1 = 32'd7; op1 = 2'b01;
        step();
        req1 = 1'b0;
        step();
        chk_rsp("sub_zero", 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0);

        // contention: last winner was 1, so grants go 0,1,0,1
        req0 = 1'b1; a0 = 32'd5; b0 = 32'd7; op0 = 2'b10;
        req1 = 1'b1; a1 = 32'd5; b1 = 32'd7; op1 = 2'b00;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rr_gnt0", 32'(gnt0), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_gnt1", 32'(gnt1), (i % 2 == 0) ? 32'd0 : 32'd1);
            step();
            if (i >= 1) begin
                if (i % 2 == 1) chk_rsp("rr_rsp0", 1'b1, 1'b0, 32'h00000007, 1'b0, 1'b0);
                else            chk_rsp("rr_rsp1", 1'b1, 1'b1, 32'h0000000C, 1'b0, 1'b0);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        chk_rsp("rr_tail", 1'b1, 1'b1, 32'h0000000C, 1'b0, 1'b0);
        step();
        chk("rr_idle", 32'(rsp_valid), 32'd0);

        // stall right after one grant
        req0 = 1'b1; req1 = 1'b1;
        #1;
        chk("stall_pre_gnt0", 32'(gnt0), 32'd1);
        step();
        stall = 1'b1;
        #1;
        chk("stall_gnt0", 32'(gnt0), 32'd0);
        chk("stall_gnt1", 32'(gnt1), 32'd0);
        step();
        chk_rsp("stall_inflight", 1'b1, 1'b0, 32'h00000007, 1'b0, 1'b0);
        step();
        chk("stall_quiet1", 32'(rsp_valid), 32'd0);
        step();
        chk("stall_quiet2", 32'(rsp_valid), 32'd0);
        stall = 1'b0;
        #1;
        chk("unstall_gnt0", 32'(gnt0), 32'd0);
        chk("unstall_gnt1", 32'(gnt1), 32'd1);
        step();
        req0 = 1'b0; req1 = 1'b0;
        step();
        chk_rsp("unstall_rsp", 1'b1, 1'b1, 32'h0000000C, 1'b0, 1'b0);

        // reset between issue and response
        req0 = 1'b1; a0 = 32'd9; b0 = 32'd3; op0 = 2'b00;
        #1;
        chk("rstmid_gnt0", 32'(gnt0), 32'd1);
        step();
        req0 = 1'b0;
        chk("rstmid_issued", alu_i1, 32'd9);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_alu_i1", alu_i1, 32'd0);
        chk("rstmid_alu_op", 32'(alu_op), 32'd0);
        chk_rsp("rstmid_rsp", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        req0 = 1'b1; req1 = 1'b1;
        a0 = 32'd5; b0 = 32'd7; op0 = 2'b10;
        step();
        chk("rstmid_no_rsp", 32'(rsp_valid), 32'd0);
        chk("rstmid_hold_gnt", 32'(gnt0 | gnt1), 32'd0);
        rst = 1'b0;
        #1;
        chk("rstrel_gnt0", 32'(gnt0), 32'd1);
        chk("rstrel_gnt1", 32'(gnt1), 32'd0);
        step();
        req0 = 1'b0; req1 = 1'b0;
        chk("rstrel_no_rsp", 32'(rsp_valid), 32'd0);
        step();
        chk_rsp("rstrel_rsp", 1'b1, 1'b0, 32'h00000007, 1'b0, 1'b0);

        // idle hold: operand and result registers keep their values
        req0 = 1'b1; a0 = 32'd5; b0 = 32'd7; op0 = 2'b00;
        step();
        req0 = 1'b0; a0 = 32'd99; b0 = 32'd1;
        step();
        chk_rsp("hold_rsp", 1'b1, 1'b0, 32'h0000000C, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_alu_i1", alu_i1, 32'd5);
            chk("hold_alu_i2", alu_i2, 32'd7);
            chk("hold_dout", rsp_dout, 32'h0000000C);
            chk("hold_valid", 32'(rsp_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
